// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request at a
// time over a req/ack handshake and drives the IF/ID pipeline register. Honours
// hazard-unit stalls and taken-branch/jump redirects; an in-flight request is always
// allowed to complete (DISCARD) so the memory never sees an abandoned address.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDiscard
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic [31:0] redirect_aligned;
  logic [31:0] pc_plus4;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic        unused_redirect_lsb;

  // Redirect targets are word aligned; the two low bits are ignored.
  assign redirect_aligned    = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign pc_plus4            = pc_q + 32'd4;

  // Request is raised only while a fetch is outstanding; address is always the PC.
  assign imem_req_o  = (state_q == StFetch) || (state_q == StDiscard);
  assign imem_addr_o = pc_q;

  // FSM next state, PC update and instruction delivery.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    hold_instr_d  = hold_instr_q;
    deliver       = 1'b0;
    deliver_instr = hold_instr_q;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end

      StFetch: begin
        if (imem_ack_i) begin
          if (flush_i) begin
            // Data belongs to the squashed path; retarget immediately.
            pc_d = redirect_aligned;
          end else if (stall_i) begin
            // Data arrived while decode is blocked; park it until release.
            hold_instr_d = imem_rdata_i;
            state_d      = StHold;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata_i;
            pc_d          = pc_plus4;
          end
        end else if (flush_i) begin
          // Request must stay stable until acked; remember where to go afterwards.
          redir_pc_d = redirect_aligned;
          state_d    = StDiscard;
        end
      end

      StHold: begin
        if (flush_i) begin
          pc_d    = redirect_aligned;
          state_d = StFetch;
        end else if (!stall_i) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          pc_d          = pc_plus4;
          state_d       = StFetch;
        end
      end

      StDiscard: begin
        if (flush_i) begin
          redir_pc_d = redirect_aligned;
        end
        if (imem_ack_i) begin
          // Returned word is from the squashed path and is dropped.
          pc_d    = flush_i ? redirect_aligned : redir_pc_q;
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // IF/ID register: flush beats stall; otherwise a cycle without delivery is a bubble.
  always_comb begin
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;

    if (flush_i) begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = 32'h0;
      if_id_pc4_d   = 32'h0;
      if_id_instr_d = NOP_INSTR;
    end else if (stall_i) begin
      if_id_valid_d = if_id_valid_q;
    end else if (deliver) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_instr_d = deliver_instr;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = 32'h0;
      if_id_pc4_d   = 32'h0;
      if_id_instr_d = NOP_INSTR;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      redir_pc_q    <= RESET_PC;
      hold_instr_q  <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_pc_q    <= redir_pc_d;
      hold_instr_q  <= hold_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  assign if_id_valid_o = if_id_valid_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_pc4_o   = if_id_pc4_q;
  assign if_id_instr_o = if_id_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Inputs change and outputs are sampled on the falling
// edge; the DUT updates on the rising edge. A second instance exercises a non-default
// RESET_PC (wrap-around) and NOP_INSTR.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        ack;

  logic        req, req2;
  logic [31:0] addr, addr2;
  logic [31:0] rdata, rdata2;
  logic        valid, valid2;
  logic [31:0] pc, pc2;
  logic [31:0] pc4, pc4_2;
  logic [31:0] instr, instr2;

  int checks = 0;
  int errors = 0;

  // Memory returns a recognisable word derived from the address.
  assign rdata  = addr | 32'hA000_0000;
  assign rdata2 = addr2 | 32'hA000_0000;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .flush_i      (flush),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_rdata_i (rdata),
    .if_id_valid_o(valid),
    .if_id_pc_o   (pc),
    .if_id_pc4_o  (pc4),
    .if_id_instr_o(instr)
  );

  if_stage #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(32'hDEAD_0000)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .flush_i      (flush),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (req2),
    .imem_addr_o  (addr2),
    .imem_ack_i   (ack),
    .imem_rdata_i (rdata2),
    .if_id_valid_o(valid2),
    .if_id_pc_o   (pc2),
    .if_id_pc4_o  (pc4_2),
    .if_id_instr_o(instr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reset held for 3 edges, checked, released; returns at the falling edge where
  // the first request is visible.
  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req, valid, instr, pc, pc4} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_ifid: got req=%b v=%b i=%h pc=%h pc4=%h expected 0", req, valid,
               instr, pc, pc4);
    end
    checks++;
    if ({addr, addr2, instr2, req2} !== {32'h0, 32'hFFFF_FFFC, 32'hDEAD_0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_addr: got a=%h a2=%h i2=%h r2=%b expected 0 fffffffc dead0000 0",
               addr, addr2, instr2, req2);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req, addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_first_req: got req=%b addr=%h expected 1 00000000", req, addr);
    end
  endtask

  task automatic test_stream();
    test_reset();
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({valid, pc, pc4, instr} !==
          {1'b1, 32'(4 * k), 32'(4 * k + 4), 32'hA000_0000 | 32'(4 * k)}) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b pc=%h pc4=%h i=%h expected pc=%h", k, valid, pc,
                 pc4, instr, 4 * k);
      end
    end
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, instr, addr} !== {1'b0, 32'h0, 32'h10}) begin
      errors++;
      $display("FAIL stream_bubble: got v=%b i=%h a=%h expected 0 0 00000010", valid, instr,
               addr);
    end
  endtask

  task automatic test_wait_states();
    test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({req, addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL wait_stable_%0d: got req=%b a=%h v=%b expected 1 0 0", k, req, addr,
                 valid);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({valid, pc, instr, addr} !== {1'b1, 32'h0, 32'hA000_0000, 32'h4}) begin
      errors++;
      $display("FAIL wait_deliver: got v=%b pc=%h i=%h a=%h expected 1 0 a0000000 4", valid,
               pc, instr, addr);
    end
    @(negedge clk);
    checks++;
    if ({valid, req, addr} !== {1'b0, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL wait_once: got v=%b req=%b a=%h expected 0 1 4", valid, req, addr);
    end
  endtask

  task automatic test_stall();
    test_reset();
    ack = 1'b1;
    repeat (2) @(negedge clk);
    // Request for 0x8 is being acked; stall on this edge.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({req, valid, pc, instr} !== {1'b0, 1'b1, 32'h4, 32'hA000_0004}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got req=%b v=%b pc=%h i=%h expected 0 1 4 a0000004", k,
                 req, valid, pc, instr);
      end
    end
    stall = 1'b0;
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, pc, pc4, instr} !== {1'b1, 32'h8, 32'hC, 32'hA000_0008}) begin
      errors++;
      $display("FAIL stall_release: got v=%b pc=%h pc4=%h i=%h expected 1 8 c a0000008", valid,
               pc, pc4, instr);
    end
    checks++;
    if ({req, addr} !== {1'b1, 32'hC}) begin
      errors++;
      $display("FAIL stall_next_req: got req=%b a=%h expected 1 c", req, addr);
    end
  endtask

  task automatic test_flush_outstanding();
    test_reset();
    ack = 1'b1;
    @(negedge clk);
    // 0x0 delivered, request 0x4 outstanding; flush to a misaligned target.
    ack = 1'b0;
    flush = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({valid, pc, instr, req, addr} !== {1'b0, 32'h0, 32'h0, 1'b1, 32'h4}) begin
      errors++;
      $display("FAIL flush_bubble: got v=%b pc=%h i=%h req=%b a=%h expected 0 0 0 1 4", valid,
               pc, instr, req, addr);
    end
    @(negedge clk);
    checks++;
    if ({req, addr} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL flush_addr_stable: got req=%b a=%h expected 1 4", req, addr);
    end
    ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, req, addr} !== {1'b0, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL flush_drop: got v=%b req=%b a=%h expected 0 1 100", valid, req, addr);
    end
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({valid, pc, instr} !== {1'b1, 32'h100, 32'hA000_0100}) begin
      errors++;
      $display("FAIL flush_target: got v=%b pc=%h i=%h expected 1 100 a0000100", valid, pc,
               instr);
    end
  endtask

  // Second flush while discarding replaces the saved target.
  task automatic test_back_to_back_flush();
    test_reset();
    flush = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h300;
    checks++;
    if ({req, addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL b2b_discard: got req=%b a=%h expected 1 0", req, addr);
    end
    @(negedge clk);
    flush = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({req, addr, valid} !== {1'b1, 32'h300, 1'b0}) begin
      errors++;
      $display("FAIL b2b_target: got req=%b a=%h v=%b expected 1 300 0", req, addr, valid);
    end
  endtask

  task automatic test_wrap_stall_flush();
    test_reset();
    checks++;
    if ({req2, addr2} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_first: got req=%b a=%h expected 1 fffffffc", req2, addr2);
    end
    ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid2, pc2, pc4_2, instr2, addr2} !==
        {1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_pc4: got v=%b pc=%h pc4=%h i=%h a=%h expected 1 fffffffc 0 fffffffc 0",
               valid2, pc2, pc4_2, instr2, addr2);
    end
    stall = 1'b1;
    flush = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    checks++;
    if ({valid2, pc2, pc4_2, instr2} !== {1'b0, 32'h0, 32'h0, 32'hDEAD_0000}) begin
      errors++;
      $display("FAIL stall_flush_bubble: got v=%b pc=%h pc4=%h i=%h expected 0 0 0 dead0000",
               valid2, pc2, pc4_2, instr2);
    end
    checks++;
    if ({req2, addr2} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL stall_flush_redirect: got req=%b a=%h expected 1 40", req2, addr2);
    end
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({valid2, pc2, instr2} !== {1'b1, 32'h40, 32'hA000_0040}) begin
      errors++;
      $display("FAIL wrap_target: got v=%b pc=%h i=%h expected 1 40 a0000040", valid2, pc2,
               instr2);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0; redirect_pc = 32'h0;
    test_stream();
    test_wait_states();
    test_stall();
    test_flush_outstanding();
    test_back_to_back_flush();
    test_wrap_stall_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
